alu: RTL and testbench
======================

Name: alu

Overview:
- Parameterised N-bit integer ALU for the RISC-V-style datapath (execute stage).
- Combinational core computes z from x, y and funct: add, sub, logic, shifts, signed and unsigned set-less-than.
- Also produces equal, zero and signed-overflow flags.
- Single clock and synchronous active-low reset; they serve only the sticky overflow status register and the optional output register.

Parameters:
- N, 32, data width in bits; must be a power of two and at least 8.
- SHW, $clog2(N), shift-amount width, derived; do not override.
- ALU_FUNCT_WIDTH, 4, macro in alu_defines.h giving the width of funct.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- x  input  N  operand A.
- y  input  N  operand B; y[SHW-1:0] is the shift amount.
- funct  input  ALU_FUNCT_WIDTH  operation select.
- clr_sticky  input  1  synchronous clear of ovf_sticky.
- z  output  N  result.
- equal  output  1  x == y.
- zero  output  1  z == 0.
- overflow  output  1  signed overflow of the current ADD/SUB.
- ovf_sticky  output  1  registered OR of overflow since the last clear.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- z, equal, zero and overflow are purely combinational in the base build: 0-cycle latency, valid within the same cycle inputs change.
- funct encoding (defines in alu_defines.h):
  - 0000 ADD: z = x + y, mod 2^N.
  - 0001 SUB: z = x - y, mod 2^N.
  - 0010 SLL: z = x << y[SHW-1:0].
  - 0011 SLT: z = 1 if $signed(x) < $signed(y), else 0.
  - 0100 SLTU: z = 1 if x < y unsigned, else 0.
  - 0101 XOR: z = x ^ y.
  - 0110 SRL: z = x >> y[SHW-1:0], zero fill.
  - 0111 SRA: arithmetic right shift, sign fill.
  - 1000 OR: z = x | y.
  - 1001 AND: z = x & y.
  - 1010-1111: z = 0, overflow = 0.
- Shifts ignore y[N-1:SHW]; a shift amount of 0 returns x unchanged.
- SLT/SLTU results are zero-extended to N bits.
- overflow:
  - ADD: set when x[N-1] == y[N-1] and z[N-1] != x[N-1].
  - SUB: set when x[N-1] != y[N-1] and z[N-1] != x[N-1].
  - All other functs: 0.
- equal is independent of funct. zero reflects the final z.
- No X propagation from unused codes; every output is driven for every funct.
- ovf_sticky, on each rising edge:
  - rst_n == 0 → 0.
  - else clr_sticky == 1 → 0. Clear wins over a simultaneous overflow.
  - else ovf_sticky |= overflow.
- Reset does not affect the combinational outputs.

Optional Feature:
- Macro ALU_OUT_REG_EN.
- Defined: z, equal, zero and overflow are registered on the rising edge of clk.
  - Latency is 1 cycle.
  - rst_n low clears all four to 0; zero resets to 0, not 1.
  - ovf_sticky samples the combinational overflow, so its timing is unchanged.
- Undefined: outputs are combinational as above, with no register or reset on the result path.

Test Plan:
- ADD x=5, y=7 → z=12, overflow=0, zero=0, equal=0. ADD x=0x7FFFFFFF, y=1 → z=0x80000000, overflow=1.
- SUB x=9, y=9 → z=0, zero=1, equal=1. SUB x=0x80000000, y=1 → z=0x7FFFFFFF, overflow=1.
- SLT x=0xFFFFFFFF (-1), y=1 → z=1. SLTU with the same operands → z=0.
- SLL x=1, y=31 → 0x80000000. SRL x=0x80000000, y=4 → 0x08000000. SRA x=0x80000000, y=4 → 0xF8000000. SLL x=3, y=0x20 (shift amount 0) → z=3.
- Logic and unused codes, with x=0xF0F0F0F0, y=0xFF00FF00:
  - AND → 0xF000F000.
  - OR → 0xFFF0FFF0.
  - XOR → 0x0FF00FF0.
  - funct=1111 → z=0, zero=1.
- Sticky flag:
  - rst_n=0 for 2 clk → ovf_sticky=0.
  - One overflowing ADD → ovf_sticky=1 on the next edge; it stays 1 through later non-overflowing ops.
  - clr_sticky together with an overflowing op → ovf_sticky=0.
  - Under ALU_OUT_REG_EN, z appears exactly one edge after the inputs.

Source files
------------

// File: rtl/alu.sv
// alu: N-bit RISC-V ALU with sticky overflow flag; define ALU_OUT_REG_EN to register z/equal/zero/overflow.
`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`endif
module alu #(
   parameter int N = 32,
   localparam int SHW = $clog2(N)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N-1:0]                x,
   input  logic [N-1:0]                y,
   input  logic [`ALU_FUNCT_WIDTH-1:0] funct,
   input  logic                        clr_sticky,
   output logic [N-1:0]                z,
   output logic                        equal,
   output logic                        zero,
   output logic                        overflow,
   output logic                        ovf_sticky
);
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_ADD  = 'd0;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_SUB  = 'd1;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_SLL  = 'd2;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_SLT  = 'd3;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_SLTU = 'd4;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_XOR  = 'd5;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_SRL  = 'd6;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_SRA  = 'd7;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_OR   = 'd8;
   localparam logic [`ALU_FUNCT_WIDTH-1:0] F_AND  = 'd9;
   logic [N-1:0]   sum, dif, zc;
   logic [SHW-1:0] sh;
   logic           ovc, eqc;
   assign sum = x + y;
   assign dif = x - y;
   assign sh  = y[SHW-1:0];
   assign eqc = x == y;
   always_comb begin
      case (funct)
         F_ADD:   zc = sum;
         F_SUB:   zc = dif;
         F_SLL:   zc = x << sh;
         F_SLT:   zc = {{(N-1){1'b0}}, $signed(x) < $signed(y)};
         F_SLTU:  zc = {{(N-1){1'b0}}, x < y};
         F_XOR:   zc = x ^ y;
         F_SRL:   zc = x >> sh;
         F_SRA:   zc = $unsigned($signed(x) >>> sh);
         F_OR:    zc = x | y;
         F_AND:   zc = x & y;
         default: zc = '0;
      endcase
   end
   assign ovc = (funct == F_ADD) ? (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]) :
                (funct == F_SUB) ? (x[N-1] != y[N-1]) && (dif[N-1] != x[N-1]) : 1'b0;
   always_ff @(posedge clk) begin
      if (!rst_n) ovf_sticky <= 1'b0;
      else        ovf_sticky <= !clr_sticky && (ovf_sticky || ovc);
   end
`ifdef ALU_OUT_REG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         z        <= '0;
         equal    <= 1'b0;
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         z        <= zc;
         equal    <= eqc;
         zero     <= zc == '0;
         overflow <= ovc;
      end
   end
`else
   assign z        = zc;
   assign equal    = eqc;
   assign zero     = zc == '0;
   assign overflow = ovc;
`endif
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed checks of alu against a plain-arithmetic reference model.
module tb_alu;
   logic        clk = 1'b0;
   logic        rst_n, clr_sticky;
   logic [31:0] x, y, z, pz, mz;
   logic [3:0]  funct;
   logic        equal, zero, overflow, ovf_sticky, mo, exp_st;
   int          total = 0, bad = 0;

   alu #(.N(32)) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .funct(funct), .clr_sticky(clr_sticky),
      .z(z), .equal(equal), .zero(zero), .overflow(overflow), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   function automatic void ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic o);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint s;
      int     amt = int'(b % 32);
      o = 1'b0;
      r = '0;
      case (f)
         4'd0: begin s = sa + sb; r = s[31:0]; o = s > 64'sd2147483647 || s < -64'sd2147483648; end
         4'd1: begin s = sa - sb; r = s[31:0]; o = s > 64'sd2147483647 || s < -64'sd2147483648; end
         4'd2: r = a << amt;
         4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd4: r = (a < b) ? 32'd1 : 32'd0;
         4'd5: r = a ^ b;
         4'd6: r = a >> amt;
         4'd7: begin s = sa >>> amt; r = s[31:0]; end
         4'd8: r = a | b;
         4'd9: r = a & b;
         default: r = '0;
      endcase
   endfunction

   always_comb ref_alu(funct, x, y, mz, mo);

   always @(posedge clk) exp_st <= !rst_n ? 1'b0 : clr_sticky ? 1'b0 : (exp_st | mo);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input logic c);
      logic [31:0] ez;
      logic        eo;
      @(negedge clk);
      funct = f; x = a; y = b; clr_sticky = c;
      ref_alu(f, a, b, ez, eo);
`ifdef ALU_OUT_REG_EN
      #1 check("z_hold", z, pz);
      @(posedge clk); #1;
`else
      #1;
`endif
      check("z", z, ez);
      check("equal", equal, a == b);
      check("zero", zero, ez == 0);
      check("overflow", overflow, eo);
`ifndef ALU_OUT_REG_EN
      @(posedge clk); #1;
`endif
      check("sticky", ovf_sticky, exp_st);
      pz = ez;
   endtask

   typedef struct { logic [3:0] f; logic [31:0] a, b, r; } vec_t;
   vec_t tp[$] = '{
      '{4'd0, 32'd5,          32'd7,          32'd12},
      '{4'd0, 32'h7FFFFFFF,   32'd1,          32'h80000000},
      '{4'd1, 32'd9,          32'd9,          32'd0},
      '{4'd1, 32'h80000000,   32'd1,          32'h7FFFFFFF},
      '{4'd3, 32'hFFFFFFFF,   32'd1,          32'd1},
      '{4'd4, 32'hFFFFFFFF,   32'd1,          32'd0},
      '{4'd2, 32'd1,          32'd31,         32'h80000000},
      '{4'd6, 32'h80000000,   32'd4,          32'h08000000},
      '{4'd7, 32'h80000000,   32'd4,          32'hF8000000},
      '{4'd2, 32'd3,          32'h20,         32'd3},
      '{4'd9, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF000F000},
      '{4'd8, 32'hF0F0F0F0,   32'hFF00FF00,   32'hFFF0FFF0},
      '{4'd5, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0},
      '{4'd15, 32'hF0F0F0F0,  32'hFF00FF00,   32'd0}
   };

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; clr_sticky = 1'b0; funct = 4'd0; x = 32'h7FFFFFFF; y = 32'd1; pz = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sticky", ovf_sticky, 0);
`ifdef ALU_OUT_REG_EN
      check("rst_z", z, 0);
      check("rst_zero", zero, 0);
`endif
      @(negedge clk) rst_n = 1'b1;
      foreach (tp[i]) begin
         step(tp[i].f, tp[i].a, tp[i].b, 1'b0);
         check($sformatf("tp%0d", i), z, tp[i].r);
      end
      step(4'd1, 32'd3, 32'd3, 1'b1);
      check("st_cleared", ovf_sticky, 0);
      step(4'd0, 32'h7FFFFFFF, 32'd1, 1'b0);
      check("st_set", ovf_sticky, 1);
      step(4'd0, 32'd5, 32'd7, 1'b0);
      check("st_keep", ovf_sticky, 1);
      step(4'd0, 32'h7FFFFFFF, 32'd1, 1'b1);
      check("st_clr_wins", ovf_sticky, 0);
      for (int i = 0; i < 400; i++)
         step(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 9) == 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
